// File: rtl/restoring_divider_6_pkg.sv
// Shared ALU divider definitions.
// Width, FSM states and the error quotient.
package restoring_divider_6_pkg;

  localparam int DIV_W = 6;

  localparam logic [DIV_W-1:0] ERR_QUOT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider_6_div_step.sv
// One restoring division step.
// Shift in a dividend bit, trial-subtract, keep or restore.
module restoring_divider_6_div_step
  import restoring_divider_6_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] i_pr,
  input  logic         i_bit,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_pr,
  output logic         o_q
);

  logic [W:0] w_sh;
  logic [W:0] w_trial;

  // The shifted remainder is below 2*divisor, so a
  // non-negative trial always fits in W bits.
  assign w_sh    = {i_pr, i_bit};
  assign w_trial = w_sh - {1'b0, i_dvs};
  assign o_q     = ~w_trial[W];
  assign o_pr    = o_q ? w_trial[W-1:0] : w_sh[W-1:0];

endmodule

// File: rtl/restoring_divider_6.sv
// Sequential restoring divider, 2W / W bits.
// One quotient bit per clock, start/busy/done handshake.
module restoring_divider_6
  import restoring_divider_6_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] op1,
  input  logic [W-1:0]   op2,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem,
  output logic           div_zero,
  output logic           ovf
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_pr;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_qsh;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic          r_dz;
  logic          r_ovf;

  logic          w_acc;
  logic          w_ezero;
  logic          w_eovf;
  logic          w_err;
  logic          w_last;
  logic [W-1:0]  w_pr;
  logic          w_q;

  assign w_acc   = start && (r_state != BUSY);
  assign w_ezero = (op2 == '0);
  assign w_eovf  = !w_ezero && (op1[2*W-1:W] >= op2);
  assign w_err   = w_ezero || w_eovf;
  assign w_last  = (r_cnt == LAST);

  restoring_divider_6_div_step #(
    .W (W)
  ) u_step (
    .i_pr  (r_pr),
    .i_bit (r_d[W-1]),
    .i_dvs (r_dvs),
    .o_pr  (w_pr),
    .o_q   (w_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: errors skip straight to DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_next = w_err ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (w_acc) begin
          w_next = w_err ? DONE : BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, iteration and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pr   <= '0;
      r_d    <= '0;
      r_dvs  <= '0;
      r_qsh  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_acc) begin
      r_cnt <= '0;
      r_qsh <= '0;
      unique case (1'b1)
        w_err: begin
          r_dz   <= w_ezero;
          r_ovf  <= w_eovf;
          r_quot <= ERR_QUOT;
          r_rem  <= '0;
        end
        default: begin
          r_pr  <= op1[2*W-1:W];
          r_d   <= op1[W-1:0];
          r_dvs <= op2;
        end
      endcase
    end else if (r_state == BUSY) begin
      r_pr  <= w_pr;
      r_d   <= {r_d[W-2:0], 1'b0};
      r_qsh <= {r_qsh[W-2:0], w_q};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot <= {r_qsh[W-2:0], w_q};
        r_rem  <= w_pr;
        r_dz   <= 1'b0;
        r_ovf  <= 1'b0;
      end
    end
  end

  assign busy     = (r_state == BUSY);
  assign done     = (r_state == DONE);
  assign quot     = r_quot;
  assign rem      = r_rem;
  assign div_zero = r_dz;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_restoring_divider_6.sv
// Directed bench for restoring_divider_6.
// Hand-computed vectors plus an invariant sweep.
module tb_restoring_divider_6;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] op1;
  logic [5:0]  op2;
  logic        busy;
  logic        done;
  logic [5:0]  quot;
  logic [5:0]  rem;
  logic        div_zero;
  logic        ovf;

  int n_chk;
  int n_fail;

  restoring_divider_6 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op1      (op1),
    .op2      (op2),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  // Present an op for one accepting edge.
  task automatic launch(input logic [11:0] a,
                        input logic [5:0] b);
    start = 1'b1;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges from acceptance (1) until done seen.
  task automatic wait_done(output int lat,
                           output int nbusy);
    lat   = 1;
    nbusy = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) nbusy++;
      lat++;
      if (lat > 20) begin
        chk("timeout", 32'(lat), 32'd7);
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic res(input string tag,
                     input int eq, input int er,
                     input int ez, input int eo);
    chk({tag, "_q"}, 32'(quot), 32'(eq));
    chk({tag, "_r"}, 32'(rem), 32'(er));
    chk({tag, "_dz"}, 32'(div_zero), 32'(ez));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int lat;
    int nb;
    int b;
    int hi;
    int lo;
    int a;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op1    = '0;
    op2    = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(12'd100, 6'd7);
    wait_done(lat, nb);
    chk("a_lat", 32'(lat), 32'd7);
    chk("a_busy", 32'(nb), 32'd6);
    res("a", 14, 2, 0, 0);

    launch(12'd4031, 6'd63);
    wait_done(lat, nb);
    chk("b_lat", 32'(lat), 32'd7);
    res("b", 63, 62, 0, 0);

    launch(12'd4095, 6'd63);
    wait_done(lat, nb);
    chk("c_lat", 32'(lat), 32'd1);
    res("c", 63, 0, 0, 1);

    launch(12'd1234, 6'd0);
    wait_done(lat, nb);
    chk("d_lat", 32'(lat), 32'd1);
    chk("d_busy", 32'(nb), 32'd0);
    chk("d_busynow", 32'(busy), 32'd0);
    res("d", 63, 0, 1, 0);

    // Start held through DONE: back-to-back accept.
    start = 1'b1;
    op1   = 12'd0;
    op2   = 6'd5;
    @(posedge clk);
    wait_done(lat, nb);
    chk("e_lat", 32'(lat), 32'd7);
    res("e", 0, 0, 0, 0);
    op1 = 12'd63;
    op2 = 6'd1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("f_b2b_busy", 32'(busy), 32'd1);
    chk("f_b2b_done", 32'(done), 32'd0);
    wait_done(lat, nb);
    chk("f_lat", 32'(lat), 32'd7);
    res("f", 63, 0, 0, 0);

    // Start during BUSY is ignored.
    launch(12'd100, 6'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    op1   = 12'd50;
    op2   = 6'd3;
    @(posedge clk);
    #1 start = 1'b0;
    op1 = 12'd4095;
    op2 = 6'd0;
    wait_done(lat, nb);
    res("g", 14, 2, 0, 0);

    // Reset in the middle of an op.
    launch(12'd200, 6'd9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("h_busy", 32'(busy), 32'd0);
    chk("h_done", 32'(done), 32'd0);
    res("h", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    launch(12'd200, 6'd9);
    wait_done(lat, nb);
    chk("i_lat", 32'(lat), 32'd7);
    res("i", 22, 2, 0, 0);

    // Sweep of non-error ops.
    for (int k = 0; k < 2000; k++) begin
      b  = int'($urandom_range(63, 1));
      hi = int'($urandom_range(b - 1, 0));
      lo = int'($urandom_range(63, 0));
      a  = hi * 64 + lo;
      launch(12'(a), 6'(b));
      wait_done(lat, nb);
      chk("s_lat", 32'(lat), 32'd7);
      chk("s_q", 32'(quot), 32'(a / b));
      chk("s_r", 32'(rem), 32'(a % b));
      chk("s_inv", 32'(int'(quot) * b + int'(rem)),
          32'(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
